// File: rtl/snake_pkg.sv
// Shared constants for the snake board: button indices, debounce default and direction codes.
package snake_pkg;

  localparam int unsigned BTN_LEFT         = 0;
  localparam int unsigned BTN_RIGHT        = 1;
  localparam int unsigned BTN_UP           = 2;
  localparam int unsigned BTN_DOWN         = 3;
  localparam int unsigned NUM_BTNS         = 4;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    RIGHT = 2'b11
  } dir_e;

  // True when exactly one button is held.
  function automatic logic single_press(input logic [NUM_BTNS-1:0] s);
    return $countones(s) == 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stability counter, debounced level and press pulse.
module debounce_channel
  import snake_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_DEFAULT,
  parameter bit          ActiveLow      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic pulse
);

  localparam int unsigned     CntW     = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(DebounceCycles - 1);
  localparam logic            Released = ActiveLow;

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            stable_q;
  logic            pulse_q;
  logic            pressed;

  // Polarity is normalised after the second synchroniser flop.
  assign pressed = sync_q[1] ^ ActiveLow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {2{Released}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      pulse_q <= 1'b0;
      if (pressed == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        stable_q <= pressed;
        cnt_q    <= '0;
        pulse_q  <= pressed;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign stable = stable_q;
  assign pulse  = pulse_q;

endmodule

// File: rtl/direction_buttons_debounce.sv
// Debounces the four direction buttons and applies the optional one-button-only mask.
module direction_buttons_debounce
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          EXCLUSIVE       = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_left_raw,
  input  logic                btn_right_raw,
  input  logic                btn_up_raw,
  input  logic                btn_down_raw,
  output logic                left,
  output logic                right,
  output logic                up,
  output logic                down,
  output logic [NUM_BTNS-1:0] press_pulse
);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] s;
  logic [NUM_BTNS-1:0] lvl;

  always_comb begin
    raw            = '0;
    raw[BTN_LEFT]  = btn_left_raw;
    raw[BTN_RIGHT] = btn_right_raw;
    raw[BTN_UP]    = btn_up_raw;
    raw[BTN_DOWN]  = btn_down_raw;
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .ActiveLow     (BTN_ACTIVE_LOW)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .stable(s[i]),
      .pulse (press_pulse[i])
    );
  end

  // Chords are ambiguous for steering, so they suppress all levels when exclusive.
  always_comb begin
    lvl = s;
    if (EXCLUSIVE && !single_press(s)) begin
      lvl = '0;
    end
  end

  assign left  = lvl[BTN_LEFT];
  assign right = lvl[BTN_RIGHT];
  assign up    = lvl[BTN_UP];
  assign down  = lvl[BTN_DOWN];

endmodule

// File: tb/tb_direction_buttons_debounce.sv
// Bench for direction_buttons_debounce: directed scenarios plus random stimulus vs a window model.
module tb_direction_buttons_debounce;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_left_raw = 1'b1, btn_right_raw = 1'b1, btn_up_raw = 1'b1, btn_down_raw = 1'b1;
  logic left, right, up, down;
  logic left_x, right_x, up_x, down_x;
  logic [3:0] press_pulse, press_pulse_x;
  logic [3:0] lvl, lvl_x;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  direction_buttons_debounce #(
    .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .EXCLUSIVE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .left(left), .right(right), .up(up), .down(down),
    .press_pulse(press_pulse)
  );

  direction_buttons_debounce #(
    .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .EXCLUSIVE(1'b0)
  ) dut_x (
    .clk(clk), .rst_n(rst_n),
    .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .left(left_x), .right(right_x), .up(up_x), .down(down_x),
    .press_pulse(press_pulse_x)
  );

  assign lvl   = {down, up, right, left};
  assign lvl_x = {down_x, up_x, right_x, left_x};

  // Reference: history of pressed samples, one per edge; the value seen by the debouncer
  // at edge k is the sample taken at edge k-2. A channel flips when its last D seen values
  // all disagree with the current stable value.
  logic [3:0] samp_q[$];
  logic [3:0] s_m, pulse_m;

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i < 8; i++) samp_q.push_back(4'b0000);
    s_m = '0;
    pulse_m = '0;
  endtask

  task automatic model_edge(input logic [3:0] pr);
    int n;
    logic [3:0] v;
    logic all_diff;
    samp_q.push_back(pr);
    if (samp_q.size() > 32) void'(samp_q.pop_front());
    n = samp_q.size();
    for (int ch = 0; ch < 4; ch++) begin
      all_diff = 1'b1;
      for (int j = 0; j < int'(D); j++) begin
        v = samp_q[n - 3 - j];
        if (v[ch] == s_m[ch]) all_diff = 1'b0;
      end
      pulse_m[ch] = 1'b0;
      if (all_diff) begin
        s_m[ch] = ~s_m[ch];
        pulse_m[ch] = s_m[ch];
      end
    end
  endtask

  function automatic logic [3:0] excl(input logic [3:0] v);
    return ($countones(v) == 1) ? v : 4'b0000;
  endfunction

  // Drive pins (active low) for one edge, then update the model and settle.
  task automatic tick(input logic [3:0] pr);
    {btn_down_raw, btn_up_raw, btn_right_raw, btn_left_raw} = ~pr;
    @(posedge clk);
    model_edge(pr);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {btn_down_raw, btn_up_raw, btn_right_raw, btn_left_raw} = 4'b1111;
    model_reset();
    #23;
    checks++;
    if (lvl !== 4'b0000 || press_pulse !== 4'b0000 || lvl_x !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held lvl=%b pulse=%b lvl_x=%b want 0000", lvl, press_pulse, lvl_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(4'b0000);
      checks++;
      if (lvl !== 4'b0000 || press_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle tick %0d lvl=%b pulse=%b want 0000", i, lvl, press_pulse);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] el, ep;
    for (int i = 1; i <= 7; i++) begin
      tick(4'b0100);
      el = (i >= 6) ? 4'b0100 : 4'b0000;
      ep = (i == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (lvl !== el || press_pulse !== ep) begin
        errors++;
        $display("FAIL clean_press tick %0d lvl=%b pulse=%b want lvl=%b pulse=%b",
                 i, lvl, press_pulse, el, ep);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      tick(4'b0000);
      el = (i == 6) ? 4'b0000 : 4'b0100;
      checks++;
      if (lvl !== el || press_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL clean_release tick %0d lvl=%b pulse=%b want lvl=%b pulse=0000",
                 i, lvl, press_pulse, el);
      end
    end
    repeat (4) tick(4'b0000);
  endtask

  task automatic test_bounce();
    logic [3:0] el;
    for (int i = 0; i < 4; i++) begin
      tick((i < 3) ? 4'b0001 : 4'b0000);
      checks++;
      if (lvl !== 4'b0000 || press_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_early tick %0d lvl=%b pulse=%b want 0000", i, lvl, press_pulse);
      end
    end
    for (int i = 1; i <= 7; i++) begin
      tick(4'b0001);
      el = (i >= 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (lvl !== el || press_pulse !== ((i == 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_settle tick %0d lvl=%b pulse=%b want lvl=%b", i, lvl,
                 press_pulse, el);
      end
    end
    repeat (8) tick(4'b0000);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 24; i++) begin
      tick((i == 0 || (i >= 11 && i < 14)) ? 4'b1000 : 4'b0000);
      checks++;
      if (down !== 1'b0 || press_pulse[3] !== 1'b0 || down_x !== 1'b0) begin
        errors++;
        $display("FAIL glitch tick %0d down=%b pulse3=%b down_x=%b want 0", i, down,
                 press_pulse[3], down_x);
      end
    end
  endtask

  task automatic test_multi_press();
    logic [3:0] el, ex, ep;
    for (int i = 1; i <= 6; i++) begin
      tick(4'b0101);
      ep = (i == 6) ? 4'b0101 : 4'b0000;
      ex = (i == 6) ? 4'b0101 : 4'b0000;
      checks++;
      if (lvl !== 4'b0000 || lvl_x !== ex || press_pulse !== ep || press_pulse_x !== ep) begin
        errors++;
        $display("FAIL multi_press tick %0d lvl=%b lvl_x=%b pulse=%b want lvl=0000 lvl_x=%b pulse=%b",
                 i, lvl, lvl_x, press_pulse, ex, ep);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      tick(4'b0100);
      el = (i == 6) ? 4'b0100 : 4'b0000;
      ex = (i == 6) ? 4'b0100 : 4'b0101;
      checks++;
      if (lvl !== el || lvl_x !== ex || press_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL multi_release tick %0d lvl=%b lvl_x=%b pulse=%b want lvl=%b lvl_x=%b pulse=0000",
                 i, lvl, lvl_x, press_pulse, el, ex);
      end
    end
    repeat (8) tick(4'b0000);
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] el;
    repeat (3) tick(4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (lvl !== 4'b0000 || press_pulse !== 4'b0000 || lvl_x !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid lvl=%b pulse=%b lvl_x=%b want 0000", lvl, press_pulse, lvl_x);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(4'b0010);
      el = (i == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (lvl !== el || press_pulse !== el) begin
        errors++;
        $display("FAIL reset_mid_recover tick %0d lvl=%b pulse=%b want %b", i, lvl,
                 press_pulse, el);
      end
    end
    repeat (8) tick(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] pr = '0;
    int hold[4] = '{0, 0, 0, 0};
    for (int t = 0; t < 600; t++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (hold[ch] == 0) begin
          pr[ch] = 1'($urandom_range(0, 1));
          hold[ch] = $urandom_range(1, 8);
        end
        hold[ch]--;
      end
      tick(pr);
      checks++;
      if (lvl !== excl(s_m) || lvl_x !== s_m || press_pulse !== pulse_m ||
          press_pulse_x !== pulse_m) begin
        errors++;
        $display("FAIL random tick %0d lvl=%b lvl_x=%b pulse=%b want lvl=%b lvl_x=%b pulse=%b",
                 t, lvl, lvl_x, press_pulse, excl(s_m), s_m, pulse_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_multi_press();
    test_reset_mid_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
